// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (8N1), 2-flop input synchronizer, mid-bit sampling.
// Defining UART_RX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 sync1_q;
   logic                 rx_s_q;

   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 sample_bit;
   logic                 bit_end;
   logic [CNT_W-1:0]     cnt_inc;

`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 parity_err_q, parity_err_d;
`endif

   // rx is asynchronous to clk; only rx_s_q may be used past this point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
      end
   end

   assign bit_end = (cnt_q == CNT_LAST);
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      sample_bit  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            // Re-check the line half a bit in; a short low pulse is a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d      = '0;
               sample_bit = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               par_d   = rx_s_q;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // A bad stop bit outranks a parity mismatch.
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
`ifdef UART_RX_PARITY_EN
               else if (^{shreg_q, par_q}) begin
                  parity_err_d = 1'b1;
                  state_d      = S_IDLE;
               end
`endif
               else begin
                  valid_d = 1'b1;
                  data_d  = shreg_q;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Each shift-register bit loads only when its own index is being sampled.
   generate
      for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shreg
         assign shreg_d[gi] = (sample_bit && (idx_q == IDX_W'(gi))) ? rx_s_q : shreg_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks pulses/data against a frame-level model.
// Parity scenarios are compiled in only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int DB  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx;
   logic [DB-1:0] data;
   logic          valid;
   logic          frame_err;
   logic          parity_err;
   logic          busy;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data       (data),
      .valid      (valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;
   int fall_cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts events and flags protocol anomalies.
   int            n_valid = 0, n_ferr = 0, n_perr = 0;
   int            n_excl = 0, n_long = 0, n_glitch = 0;
   int            valid_cyc_q[$];
   logic [DB-1:0] valid_data_q[$];
   logic          prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;
   logic [DB-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         n_valid++;
         valid_cyc_q.push_back(cyc);
         valid_data_q.push_back(data);
      end
      if (frame_err === 1'b1) n_ferr++;
      if (parity_err === 1'b1) n_perr++;
      if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) n_excl++;
      if ((valid && prev_v) || (frame_err && prev_f) || (parity_err && prev_p)) n_long++;
      if (rst_n && !valid && data !== prev_data) n_glitch++;
      prev_v    = valid;
      prev_f    = frame_err;
      prev_p    = parity_err;
      prev_data = data;
   end

   // Reference model state: last byte that must be visible on data.
   logic [DB-1:0] exp_data = '0;

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget (cyc=%0d, required finish earlier)", cyc);
      $fatal(1);
   end

   // Frame bits at pct% of nominal bit time; boundaries are rounded cumulatively.
   task automatic send_frame(input logic [DB-1:0] b, input logic par, input logic stop, input int pct);
      logic [11:0] bits;
      int          nb;
      int          t_prev;
      int          t_next;
`ifdef UART_RX_PARITY_EN
      bits = {1'b1, stop, par, b, 1'b0};
      nb   = DB + 3;
`else
      bits = {1'b1, par, stop, b, 1'b0};
      nb   = DB + 2;
`endif
      $display("frame: byte=%h par=%b stop=%b baud=%0d%% at cycle %0d", b, par, stop, pct, cyc);
      fall_cyc = cyc;
      t_prev   = 0;
      for (int i = 0; i < nb; i++) begin
         t_next = ((i + 1) * CPB * pct + 50) / 100;
         rx     = bits[i];
         repeat (t_next - t_prev) @(negedge clk);
         t_prev = t_next;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      total_cnt++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else pass_cnt++;
      total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else pass_cnt++;
      total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
      total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", parity_err); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single();
      int v0;
      int lat;
      v0 = n_valid;
      send_frame(8'h55, ^8'h55, 1'b1, 100);
      repeat (4) @(negedge clk);
      exp_data = 8'h55;
      total_cnt++; if (n_valid - v0 !== 1) $display("FAIL single_count: got %0d pulses want 1", n_valid - v0); else pass_cnt++;
      total_cnt++; if (data !== exp_data) $display("FAIL single_data: got %h want %h", data, exp_data); else pass_cnt++;
      lat = (valid_cyc_q.size() > 0) ? valid_cyc_q[valid_cyc_q.size() - 1] - fall_cyc : -1;
`ifdef UART_RX_PARITY_EN
      total_cnt++; if (lat < 169 || lat > 171) $display("FAIL single_latency: got %0d want 170+-1", lat); else pass_cnt++;
`else
      total_cnt++; if (lat < 153 || lat > 155) $display("FAIL single_latency: got %0d want 154+-1", lat); else pass_cnt++;
`endif
      total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int v0, f0, p0, gap;
      v0 = valid_cyc_q.size();
      f0 = n_ferr;
      p0 = n_perr;
      send_frame(8'hA5, ^8'hA5, 1'b1, 100);
      send_frame(8'h3C, ^8'h3C, 1'b1, 100);
      repeat (4) @(negedge clk);
      exp_data = 8'h3C;
      total_cnt++; if (valid_cyc_q.size() - v0 !== 2) $display("FAIL b2b_count: got %0d pulses want 2", valid_cyc_q.size() - v0); else pass_cnt++;
      if (valid_cyc_q.size() >= v0 + 2) begin
         gap = valid_cyc_q[v0 + 1] - valid_cyc_q[v0];
`ifdef UART_RX_PARITY_EN
         total_cnt++; if (gap < 175 || gap > 177) $display("FAIL b2b_spacing: got %0d want 176", gap); else pass_cnt++;
`else
         total_cnt++; if (gap < 159 || gap > 161) $display("FAIL b2b_spacing: got %0d want 160", gap); else pass_cnt++;
`endif
         total_cnt++; if (valid_data_q[v0] !== 8'hA5) $display("FAIL b2b_data0: got %h want a5", valid_data_q[v0]); else pass_cnt++;
         total_cnt++; if (valid_data_q[v0 + 1] !== 8'h3C) $display("FAIL b2b_data1: got %h want 3c", valid_data_q[v0 + 1]); else pass_cnt++;
      end
      total_cnt++; if ((n_ferr - f0) + (n_perr - p0) !== 0) $display("FAIL b2b_errors: got %0d error pulses want 0", (n_ferr - f0) + (n_perr - p0)); else pass_cnt++;
   endtask

   task automatic test_glitch();
      int v0, f0;
      v0 = n_valid;
      f0 = n_ferr;
      $display("glitch: rx low for 4 cycles at cycle %0d", cyc);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      total_cnt++; if (n_valid - v0 !== 0) $display("FAIL glitch_valid: got %0d pulses want 0", n_valid - v0); else pass_cnt++;
      total_cnt++; if (n_ferr - f0 !== 0) $display("FAIL glitch_ferr: got %0d pulses want 0", n_ferr - f0); else pass_cnt++;
      total_cnt++; if (data !== exp_data) $display("FAIL glitch_data: got %h want %h", data, exp_data); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_frame_error();
      int v0, f0;
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(8'h81, ^8'h81, 1'b0, 100);
      repeat (100) @(negedge clk);
      total_cnt++; if (busy !== 1'b1) $display("FAIL ferr_busy_held: got %b want 1", busy); else pass_cnt++;
      rx = 1'b1;
      repeat (6) @(negedge clk);
      total_cnt++; if (n_ferr - f0 !== 1) $display("FAIL ferr_count: got %0d pulses want 1", n_ferr - f0); else pass_cnt++;
      total_cnt++; if (n_valid - v0 !== 0) $display("FAIL ferr_valid: got %0d pulses want 0", n_valid - v0); else pass_cnt++;
      total_cnt++; if (data !== exp_data) $display("FAIL ferr_data: got %h want %h", data, exp_data); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL ferr_busy_after: got %b want 0", busy); else pass_cnt++;
      send_frame(8'h42, ^8'h42, 1'b1, 100);
      repeat (4) @(negedge clk);
      exp_data = 8'h42;
      total_cnt++; if (data !== exp_data) $display("FAIL ferr_recover: got %h want %h", data, exp_data); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      int v0, f0;
      v0 = n_valid;
      f0 = n_ferr;
      fork
         send_frame(8'hC3, ^8'hC3, 1'b1, 100);
         begin
            repeat (5 * CPB + CPB / 2) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            total_cnt++; if (data !== 8'h00) $display("FAIL midrst_data: got %h want 00", data); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
            total_cnt++; if (valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", valid); else pass_cnt++;
            total_cnt++; if (frame_err !== 1'b0) $display("FAIL midrst_ferr: got %b want 0", frame_err); else pass_cnt++;
            total_cnt++; if (parity_err !== 1'b0) $display("FAIL midrst_perr: got %b want 0", parity_err); else pass_cnt++;
         end
      join
      exp_data = 8'h00;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      total_cnt++; if ((n_valid - v0) + (n_ferr - f0) !== 0) $display("FAIL midrst_pulses: got %0d want 0", (n_valid - v0) + (n_ferr - f0)); else pass_cnt++;
      send_frame(8'h7E, ^8'h7E, 1'b1, 100);
      repeat (4) @(negedge clk);
      exp_data = 8'h7E;
      total_cnt++; if (n_valid - v0 !== 1) $display("FAIL midrst_recover_count: got %0d want 1", n_valid - v0); else pass_cnt++;
      total_cnt++; if (data !== exp_data) $display("FAIL midrst_recover_data: got %h want %h", data, exp_data); else pass_cnt++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0, p0;
      v0 = n_valid;
      p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b1, 100);
      repeat (4) @(negedge clk);
      exp_data = 8'h07;
      total_cnt++; if (n_valid - v0 !== 1) $display("FAIL parity_good_valid: got %0d want 1", n_valid - v0); else pass_cnt++;
      total_cnt++; if (data !== exp_data) $display("FAIL parity_good_data: got %h want %h", data, exp_data); else pass_cnt++;
      send_frame(8'h07, 1'b0, 1'b1, 100);
      repeat (4) @(negedge clk);
      total_cnt++; if (n_perr - p0 !== 1) $display("FAIL parity_bad_perr: got %0d want 1", n_perr - p0); else pass_cnt++;
      total_cnt++; if (n_valid - v0 !== 1) $display("FAIL parity_bad_valid: got %0d want 1", n_valid - v0); else pass_cnt++;
      total_cnt++; if (data !== exp_data) $display("FAIL parity_bad_data: got %h want %h", data, exp_data); else pass_cnt++;
   endtask
`endif

   // Random frames at 98/100/102% baud; model decides valid / frame_err / parity_err.
   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         logic [DB-1:0] b;
         logic          stop, par, par_ok;
         int            pct, v0, f0, p0;
         int            ev, ef, ep;
         b    = DB'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         par  = (^b) ^ ($urandom_range(0, 4) == 0);
         pct  = 98 + 2 * $urandom_range(0, 2);
`ifdef UART_RX_PARITY_EN
         par_ok = ((^b) == par);
`else
         par_ok = 1'b1;
`endif
         ev = 0; ef = 0; ep = 0;
         if (!stop) ef = 1;
         else if (!par_ok) ep = 1;
         else ev = 1;
         v0 = n_valid; f0 = n_ferr; p0 = n_perr;
         send_frame(b, par, stop, pct);
         if (!stop) begin
            repeat (20) @(negedge clk);
            rx = 1'b1;
            repeat (4) @(negedge clk);
         end else begin
            repeat (2 + $urandom_range(0, 8)) @(negedge clk);
         end
         if (ev == 1) exp_data = b;
         total_cnt++; if (n_valid - v0 !== ev) $display("FAIL rand%0d_valid: got %0d want %0d", n, n_valid - v0, ev); else pass_cnt++;
         total_cnt++; if (n_ferr - f0 !== ef) $display("FAIL rand%0d_ferr: got %0d want %0d", n, n_ferr - f0, ef); else pass_cnt++;
         total_cnt++; if (n_perr - p0 !== ep) $display("FAIL rand%0d_perr: got %0d want %0d", n, n_perr - p0, ep); else pass_cnt++;
         total_cnt++; if (data !== exp_data) $display("FAIL rand%0d_data: got %h want %h", n, data, exp_data); else pass_cnt++;
      end
   endtask

   task automatic test_invariants();
      total_cnt++; if (n_excl !== 0) $display("FAIL pulse_exclusive: got %0d overlaps want 0", n_excl); else pass_cnt++;
      total_cnt++; if (n_long !== 0) $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", n_long); else pass_cnt++;
      total_cnt++; if (n_glitch !== 0) $display("FAIL data_hold: got %0d unstrobed changes want 0", n_glitch); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      test_invariants();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver (8N1 by default). It is the receive end of the team's UART link and pairs with the serial transmitter.
- Converts a 1-bit idle-high line into parallel bytes and issues a one-cycle valid strobe per frame.
- Sits between an external pin and on-board logic, such as LEDs or a seven-segment display.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be even and >= 4.
- DATA_BITS, 8: data bits per frame, sent LSB first. Range 5..9.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idle = 1; asynchronous to clk.
- data  output  DATA_BITS  last correctly received word.
- valid  output  1  one-cycle pulse; data is new.
- frame_err  output  1  one-cycle pulse; stop bit sampled 0.
- parity_err  output  1  one-cycle pulse; parity mismatch. Tied 0 when the optional feature is off.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: asynchronous, active-low (rst_n=0).
  - State = IDLE, data = 0, valid = frame_err = parity_err = busy = 0.
  - Both synchronizer flops = 1, bit counter = 0, clock counter = 0.
- Input path:
  - rx passes through a 2-flop synchronizer, giving rx_s.
  - All decisions use rx_s; the raw rx is never used.
- Counters:
  - Clock counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Bit index counts 0..DATA_BITS-1.
- States: IDLE, START, DATA, PARITY (feature only), STOP, BREAK.
  - IDLE: rx_s=0 -> START, clock counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - 0 -> DATA, counter cleared.
    - 1 -> IDLE (glitch rejected; no outputs pulsed).
  - DATA: at each count CLKS_PER_BIT-1, sample rx_s into the shift register at the current bit index (LSB first).
    - After bit DATA_BITS-1 -> PARITY if enabled, else STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s.
    - 1 -> data <= shift register; valid=1 for exactly one cycle; -> IDLE.
    - 0 -> frame_err=1 for one cycle; data unchanged; -> BREAK.
  - BREAK: stay until rx_s=1, then -> IDLE. A held-low line never produces a false frame.
- Timing:
  - Sampling is mid-bit; samples land CLKS_PER_BIT/2 cycles after each nominal bit edge.
  - Latency from rx falling edge to the valid pulse, defaults, no parity: 2 + 8 + 9*16 = 154 cycles. The bench tolerates ±1.
- Output rules:
  - valid, frame_err and parity_err are mutually exclusive.
  - Each pulse is high for exactly one cycle per frame.
- data holding:
  - data holds its value between valid pulses.
  - data is never changed by an errored frame.
- Back-to-back frames: a start bit immediately following a stop bit is accepted. IDLE reacts in the cycle after the STOP sample, and the half-bit margin absorbs this.
- Reset mid-frame: aborts immediately; no pulse; data returns to 0.
- Baud tolerance: no drift correction; ±2% mismatch must still decode.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one bit at count CLKS_PER_BIT-1.
  - Even parity: the XOR of the data bits and the parity bit must equal 0.
  - Mismatch: parity_err pulses in place of valid at the STOP sample, and data is not updated.
  - A failing stop bit still takes priority: frame_err, -> BREAK.
  - Default latency becomes 170 cycles.
- Undefined: no PARITY state; parity_err is constant 0; frame format is 8N1.

Test Plan:
- Reset, then send 0x55 at 16 clocks/bit -> one valid pulse at about 154 cycles; data=0x55; busy low afterwards.
- Back-to-back frames 0xA5 then 0x3C with no idle gap -> two valid pulses 160 cycles apart; data=0xA5 then 0x3C; no errors.
- Pulse rx low for 4 cycles, then high -> returns to IDLE; no valid, no frame_err; data unchanged.
- Send 0x81 with stop bit 0, hold rx low 100 cycles, then release -> frame_err once; data keeps its previous value; then a clean 0x42 frame gives valid with data=0x42.
- Assert rst_n=0 during data bit 4 of a frame -> all outputs 0 immediately; the following clean frame 0x7E decodes correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first gives valid, data=0x07; second gives parity_err, data stays 0x07.
